// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter.
// A byte FIFO accepts bytes from the core through a valid/ready handshake.
// A frame FSM pops one byte per frame and shifts it out LSB first as start, 8 data and stop bits.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_valid,
    output logic       tx_byte_ready,
    output logic       tx_serial,
    output logic       tx_busy
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CLK_W  = 32;
    localparam int unsigned DATA_W = 8;

    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // Frame engine state
    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [2:0]        bit_idx_q;
    logic [CLK_W-1:0]  clk_cnt_q;
    logic              tx_serial_q;

    logic push_c;
    logic pop_c;
    logic bit_done_c;
    logic fifo_nonempty_c;

    // Handshake and frame-load decode from registered state only
    always_comb begin
        fifo_nonempty_c = (count_q != '0);
        bit_done_c      = (clk_cnt_q == CLK_LAST);
        push_c          = tx_byte_valid && (count_q != CNT_FULL);
        pop_c           = fifo_nonempty_c &&
                          ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done_c));
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO data array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= tx_byte;
        end
    end

    // Frame FSM: start bit, eight data bits LSB first, stop bit, back-to-back when more data waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            clk_cnt_q   <= '0;
            tx_serial_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_serial_q <= 1'b1;
                    clk_cnt_q   <= '0;
                    if (pop_c) begin
                        shift_q     <= mem_q[rd_ptr_q];
                        bit_idx_q   <= '0;
                        tx_serial_q <= 1'b0;
                        state_q     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done_c) begin
                        clk_cnt_q   <= '0;
                        tx_serial_q <= shift_q[0];
                        state_q     <= ST_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CLK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_done_c) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == BIT_LAST) begin
                            tx_serial_q <= 1'b1;
                            state_q     <= ST_STOP;
                        end else begin
                            // Next bit sits at position 1 before the shift lands
                            bit_idx_q   <= bit_idx_q + 3'd1;
                            shift_q     <= {1'b0, shift_q[DATA_W-1:1]};
                            tx_serial_q <= shift_q[1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CLK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_done_c) begin
                        clk_cnt_q <= '0;
                        if (pop_c) begin
                            shift_q     <= mem_q[rd_ptr_q];
                            bit_idx_q   <= '0;
                            tx_serial_q <= 1'b0;
                            state_q     <= ST_START;
                        end else begin
                            tx_serial_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CLK_W'(1);
                    end
                end
                default: begin
                    clk_cnt_q   <= '0;
                    tx_serial_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Output drive
    assign tx_serial     = tx_serial_q;
    assign tx_byte_ready = (count_q != CNT_FULL);
    assign tx_busy       = (state_q != ST_IDLE) || fifo_nonempty_c;

endmodule
